// File: rtl/module_fetch_unit.sv
// rtl/module_fetch_unit.sv - instruction fetch stage: PC, memory address/write port, decode-facing outputs
// Drives a one-cycle registered instruction memory; program-load mode shares the same port.
module module_fetch_unit #(
  parameter int ADDRESS_BITS = 32,
  parameter int WORD_SIZE    = 32,
  parameter int MEMORY       = 1024,
  parameter int RESET_PC     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    load_en,
  input  logic [ADDRESS_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]    load_data,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  output logic                    imem_wr_en,
  output logic [WORD_SIZE-1:0]    imem_code,
  input  logic [WORD_SIZE-1:0]    imem_instruction,
  output logic [ADDRESS_BITS-1:0] if_pc,
  output logic [WORD_SIZE-1:0]    if_instruction,
  output logic                    if_valid
);

  localparam logic [ADDRESS_BITS-1:0] PC_RST   = ADDRESS_BITS'(RESET_PC);
  localparam logic [ADDRESS_BITS-1:0] PC_LAST  = ADDRESS_BITS'(MEMORY - 1);
  localparam logic [ADDRESS_BITS-1:0] MEM_SIZE = ADDRESS_BITS'(MEMORY);

  typedef enum logic {S_FETCH, S_LOAD} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ADDRESS_BITS-1:0] if_pc_q, if_pc_d;
  logic                    if_valid_q, if_valid_d;

  function automatic logic [ADDRESS_BITS-1:0] wrap_inc(input logic [ADDRESS_BITS-1:0] a);
    return (a == PC_LAST) ? '0 : a + ADDRESS_BITS'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    imem_addr  = pc_q;
    imem_wr_en = 1'b0;
    imem_code  = '0;

    if (reset) begin
      imem_addr  = PC_RST;
      state_d    = S_FETCH;
      pc_d       = PC_RST;
      if_pc_d    = PC_RST;
      if_valid_d = 1'b0;
    end else if (load_en) begin
      imem_wr_en = 1'b1;
      imem_addr  = load_addr;
      imem_code  = load_data;
      state_d    = S_LOAD;
      pc_d       = PC_RST;
      if_valid_d = 1'b0;
    end else if (state_q == S_LOAD) begin
      // Load exit is an unconditional fetch from the reset vector.
      imem_addr  = PC_RST;
      state_d    = S_FETCH;
      if_pc_d    = PC_RST;
      if_valid_d = 1'b1;
      pc_d       = wrap_inc(PC_RST);
    end else if (branch_taken) begin
      imem_addr  = branch_target;
      if_pc_d    = branch_target;
      if_valid_d = 1'b1;
      pc_d       = wrap_inc(branch_target);
    end else if (stall) begin
      // Re-read the held word so the registered memory output stays stable.
      imem_addr  = if_pc_q;
    end else begin
      imem_addr  = pc_q;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = wrap_inc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_RST;
      if_pc_q    <= PC_RST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign if_pc          = if_pc_q;
  assign if_valid       = if_valid_q;
  assign if_instruction = imem_instruction;

`ifndef SYNTHESIS
  assert property (@(posedge clk)
    (!reset && !load_en && state_q == S_FETCH && branch_taken) |-> (branch_target < MEM_SIZE));
`endif

endmodule
